// File: rtl/rx_pkt_pkg.sv
// Shared definitions for the receive-side packet deframer.
// Contents: parser state enum, err_code values, clogb2 helper.
package rx_pkt_pkg;

  typedef enum logic [1:0] {
    S_CMD  = 2'd0,
    S_LEN  = 2'd1,
    S_DATA = 2'd2,
    S_SUM  = 2'd3
  } rx_state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_SUM     = 2'd1;
  localparam logic [1:0] ERR_LINE    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Ceiling log2; number of address bits needed for 'value' entries.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_idle_timer.sv
// Idle watchdog for the packet parser.
// Ports: clk, reset (async active-low), run (count enable), clear (sync
// clear, wins over run), expired (registered, high while count == LIMIT).
module rx_idle_timer
  import rx_pkt_pkg::*;
#(
  parameter int unsigned LIMIT = 8679
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CW = clogb2(LIMIT + 1) + 1;

  logic [CW-1:0] count;

  // Counts idle cycles; expired rises in the cycle the count reaches LIMIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (clear || !run) begin
      count   <= '0;
      expired <= 1'b0;
    end else begin
      count   <= count + CW'(1);
      expired <= (count == CW'(LIMIT - 1));
    end
  end

endmodule

// File: rtl/rx_packet_parser.sv
// Receive-side deframer for [CMD][LEN][DATA x N][~SUM] packets.
// Build option: define RX_TIMEOUT_EN to abort packets after an idle gap.
// Ports:
//   clk, reset (async active-low)
//   rx_data/rx_valid/rx_err : byte stream from the UART receiver
//   wr_data/wr_addr/wr_clock: payload write port to the buffer
//   cmd_rx/len_rx           : header of the last completed packet
//   pckt_done/err_code      : end-of-packet pulse and status
//   busy                    : a packet is in progress
module rx_packet_parser
  import rx_pkt_pkg::*;
#(
  parameter int unsigned CLOCK        = 50_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned NUMBER       = 256,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  input  logic                        rx_err,
  output logic [7:0]                  wr_data,
  output logic [clogb2(NUMBER)-1:0]   wr_addr,
  output logic                        wr_clock,
  output logic [7:0]                  cmd_rx,
  output logic [7:0]                  len_rx,
  output logic                        pckt_done,
  output logic [1:0]                  err_code,
  output logic                        busy
);

  localparam int unsigned AW = clogb2(NUMBER);
  localparam int unsigned CW = AW + 1;

  rx_state_t     state_q, state_d;
  logic [7:0]    cmd_q, cmd_d, len_q, len_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d, target_q, target_d;
  logic [7:0]    wr_data_d, cmd_rx_d, len_rx_d;
  logic [AW-1:0] wr_addr_d;
  logic          wr_clock_d, pckt_done_d, busy_d;
  logic [1:0]    err_code_d;
  logic          timeout_hit;

`ifdef RX_TIMEOUT_EN
  localparam int unsigned TIMEOUT_LIMIT = TIMEOUT_BITS * (CLOCK / BAUD) - 1;

  logic timer_run, timer_clear;
  assign timer_run   = (state_q != S_CMD);
  assign timer_clear = rx_valid | rx_err | (state_q == S_CMD);

  rx_idle_timer #(
    .LIMIT (TIMEOUT_LIMIT)
  ) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .run     (timer_run),
    .clear   (timer_clear),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and next-output logic; line errors beat bytes, bytes beat timeout.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    target_d    = target_q;
    wr_data_d   = wr_data;
    wr_addr_d   = wr_addr;
    wr_clock_d  = 1'b0;
    pckt_done_d = 1'b0;
    err_code_d  = err_code;
    cmd_rx_d    = cmd_rx;
    len_rx_d    = len_rx;

    if ((state_q != S_CMD) && rx_err) begin
      pckt_done_d = 1'b1;
      err_code_d  = ERR_LINE;
      cmd_rx_d    = cmd_q;
      len_rx_d    = len_q;
      state_d     = S_CMD;
    end else if (rx_valid && !rx_err) begin
      case (state_q)
        S_CMD: begin
          cmd_d   = rx_data;
          sum_d   = rx_data;
          state_d = S_LEN;
        end
        S_LEN: begin
          len_d    = rx_data;
          sum_d    = sum_q + rx_data;
          target_d = (rx_data == 8'd0) ? CW'(NUMBER) : CW'(rx_data);
          cnt_d    = '0;
          state_d  = S_DATA;
        end
        S_DATA: begin
          wr_data_d  = rx_data;
          wr_addr_d  = AW'(cnt_q);
          wr_clock_d = 1'b1;
          sum_d      = sum_q + rx_data;
          cnt_d      = cnt_q + CW'(1);
          if ((cnt_q + CW'(1)) == target_q) state_d = S_SUM;
        end
        S_SUM: begin
          pckt_done_d = 1'b1;
          err_code_d  = (rx_data == ~sum_q) ? ERR_OK : ERR_SUM;
          cmd_rx_d    = cmd_q;
          len_rx_d    = len_q;
          state_d     = S_CMD;
        end
        default: state_d = S_CMD;
      endcase
    end else if ((state_q != S_CMD) && timeout_hit) begin
      pckt_done_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      cmd_rx_d    = cmd_q;
      len_rx_d    = len_q;
      state_d     = S_CMD;
    end

    busy_d = (state_d != S_CMD);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_CMD;
      cmd_q     <= '0;
      len_q     <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      target_q  <= '0;
      wr_data   <= '0;
      wr_addr   <= '0;
      wr_clock  <= 1'b0;
      cmd_rx    <= '0;
      len_rx    <= '0;
      pckt_done <= 1'b0;
      err_code  <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      wr_data   <= wr_data_d;
      wr_addr   <= wr_addr_d;
      wr_clock  <= wr_clock_d;
      cmd_rx    <= cmd_rx_d;
      len_rx    <= len_rx_d;
      pckt_done <= pckt_done_d;
      err_code  <= err_code_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_rx_packet_parser.sv
// Randomized self-checking bench for rx_packet_parser. Expected writes and
// completion pulses are derived from the byte list of each packet sent.
module tb_rx_packet_parser;

  localparam int NUMBER      = 256;
  localparam int TIMEOUT_CYC = 20 * (50_000_000 / 115_200);

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [7:0] wr_data;
  logic [7:0] wr_addr;
  logic       wr_clock;
  logic [7:0] cmd_rx;
  logic [7:0] len_rx;
  logic       pckt_done;
  logic [1:0] err_code;
  logic       busy;

  rx_packet_parser dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .wr_data   (wr_data),
    .wr_addr   (wr_addr),
    .wr_clock  (wr_clock),
    .cmd_rx    (cmd_rx),
    .len_rx    (len_rx),
    .pckt_done (pckt_done),
    .err_code  (err_code),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct { int stamp; int addr; int data; } wr_ev_t;
  typedef struct { int stamp; int err; int cmd; int len; } done_ev_t;

  wr_ev_t     exp_wr[$];
  done_ev_t   exp_done[$];
  logic [7:0] pkt_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         last_len = 0;
  int         last_stamp = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Cycle stamps and comparison of every write strobe and completion pulse.
  initial begin
    wr_ev_t   w;
    done_ev_t d;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (reset) begin
        if (wr_clock) begin
          if (exp_wr.size() == 0) check("wr_unexpected", 32'(wr_clock), 0);
          else begin
            w = exp_wr.pop_front();
            check("wr_cycle", cyc, w.stamp);
            check("wr_addr", 32'(wr_addr), w.addr);
            check("wr_data", 32'(wr_data), w.data);
          end
        end else if (exp_wr.size() > 0 && exp_wr[0].stamp <= cyc) begin
          check("wr_missing", 32'(wr_clock), 1);
          void'(exp_wr.pop_front());
        end
        if (pckt_done) begin
          if (exp_done.size() == 0) check("done_unexpected", 32'(pckt_done), 0);
          else begin
            d = exp_done.pop_front();
            check("done_cycle", cyc, d.stamp);
            check("err_code", 32'(err_code), d.err);
            check("cmd_rx", 32'(cmd_rx), d.cmd);
            check("len_rx", 32'(len_rx), d.len);
          end
        end else if (exp_done.size() > 0 && exp_done[0].stamp <= cyc) begin
          check("done_missing", 32'(pckt_done), 1);
          void'(exp_done.pop_front());
        end
      end
    end
  end

  task automatic send_byte(input logic v, input logic e, input logic [7:0] d, input logic exp_busy);
    rx_valid = v;
    rx_err   = e;
    rx_data  = d;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    check("busy", 32'(busy), 32'(exp_busy));
  endtask

  // Sends pkt_q; err_pos replaces that byte with a line error, stop_at halts early.
  task automatic send_packet(input int err_pos, input int stop_at, input int max_gap);
    int       sum;
    int       n;
    bit       last;
    wr_ev_t   w;
    done_ev_t d;
    sum = 0;
    n   = pkt_q.size();
    for (int i = 0; i < n; i++) begin
      if (i == stop_at) break;
      if (i == err_pos) begin
        d.stamp = cyc + 1; d.err = 2; d.cmd = pkt_q[0];
        d.len   = (i >= 2) ? int'(pkt_q[1]) : last_len;
        exp_done.push_back(d);
        send_byte(1'($urandom_range(0, 1)), 1'b1, pkt_q[i], 1'b0);
        break;
      end
      last = (i == n - 1);
      last_stamp = cyc + 1;
      if (i >= 2 && !last) begin
        w.stamp = cyc + 1; w.addr = i - 2; w.data = pkt_q[i];
        exp_wr.push_back(w);
      end
      if (last) begin
        d.stamp = cyc + 1; d.cmd = pkt_q[0]; d.len = pkt_q[1];
        d.err   = (pkt_q[i] == ~8'(sum)) ? 0 : 1;
        exp_done.push_back(d);
      end
      if (i == 1) last_len = pkt_q[1];
      sum = (sum + pkt_q[i]) % 256;
      send_byte(1'b1, 1'b0, pkt_q[i], !last);
      if (!last && max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
    end
  endtask

  // Builds a packet of length field 'len'; pat=1 gives data bytes equal to their index.
  task automatic build_packet(input logic [7:0] cmd, input int len, input int pat, input bit bad);
    int         n;
    logic [7:0] s;
    n = (len == 0) ? NUMBER : len;
    pkt_q.delete();
    pkt_q.push_back(cmd);
    pkt_q.push_back(8'(len));
    for (int i = 0; i < n; i++) pkt_q.push_back(pat ? 8'(i) : 8'($urandom_range(0, 255)));
    s = 8'd0;
    foreach (pkt_q[i]) s = s + pkt_q[i];
    s = ~s;
    if (bad) s = s ^ 8'($urandom_range(1, 255));
    pkt_q.push_back(s);
  endtask

  initial begin
    #(10 * 200_000);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         len, err_pos, stop_at;
    bit         bad;
    done_ev_t   d;
    reset = 1'b0; rx_valid = 1'b0; rx_err = 1'b0; rx_data = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(pckt_done), 0);
    check("rst_wr_clock", 32'(wr_clock), 0);
    check("rst_err_code", 32'(err_code), 0);
    check("rst_cmd_rx", 32'(cmd_rx), 0);
    check("rst_len_rx", 32'(len_rx), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    pkt_q = '{8'h12, 8'h02, 8'hAA, 8'h55, 8'hEC};
    send_packet(-1, -1, 2);
    repeat (2) @(negedge clk);
    pkt_q = '{8'h12, 8'h02, 8'hAA, 8'h55, 8'hED};
    send_packet(-1, -1, 0);
    build_packet(8'h12, 0, 1, 1'b0);
    send_packet(-1, -1, 0);
    repeat (2) @(negedge clk);
    build_packet(8'h34, 4, 0, 1'b0);
    send_packet(3, -1, 1);
    pkt_q = '{8'h12, 8'h02, 8'hAA, 8'h55, 8'hEC};
    send_packet(-1, -1, 0);
    repeat (3) @(negedge clk);

    // Reset mid-packet: no completion, outputs cleared, next packet clean.
    build_packet(8'h56, 5, 0, 1'b0);
    send_packet(-1, 3, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_cmd_rx", 32'(cmd_rx), 0);
    check("midrst_len_rx", 32'(len_rx), 0);
    check("midrst_wr_clock", 32'(wr_clock), 0);
    last_len = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    pkt_q = '{8'h12, 8'h02, 8'hAA, 8'h55, 8'hEC};
    send_packet(-1, -1, 0);

    // Random traffic, including idle-state line errors and back-to-back packets.
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 7) == 0) send_byte(1'($urandom_range(0, 1)), 1'b1, 8'($urandom), 1'b0);
      len     = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 12));
      bad     = ($urandom_range(0, 4) == 0);
      build_packet(8'($urandom), len, 0, bad);
      err_pos = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, pkt_q.size() - 1)) : -1;
      send_packet(err_pos, -1, 3);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (4) @(negedge clk);

`ifdef RX_TIMEOUT_EN
    pkt_q = '{8'h12, 8'h02, 8'hAA, 8'h55, 8'hEC};
    stop_at = 3;
    send_packet(-1, stop_at, 0);
    d.stamp = last_stamp + TIMEOUT_CYC; d.err = 3; d.cmd = 8'h12; d.len = 8'h02;
    exp_done.push_back(d);
    repeat (TIMEOUT_CYC + 20) @(negedge clk);
    check("timeout_busy", 32'(busy), 0);
`else
    stop_at = -1;
    d.stamp = 0;
`endif

    repeat (5) @(negedge clk);
    check("wr_left", 32'(exp_wr.size()), 0);
    check("done_left", 32'(exp_done.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_packet_parser.md
Name: rx_packet_parser

Overview:
- Receive-side packet deframer. It consumes bytes from the UART byte receiver and mirrors the TX framer format: [CMD][LEN][DATA x N][~SUM].
- Payload bytes are written into a dual-port buffer. Command, length and status are reported to the control logic in a one-cycle completion pulse.
- It sits directly between the RX byte receiver and the command/flash-update controller.

Parameters:
- CLOCK, 50_000_000: system clock frequency in Hz. Used only for the timeout.
- BAUD, 115_200: line rate. Bit time = CLOCK/BAUD clocks, integer-truncated (434 at defaults).
- NUMBER, 256: payload buffer depth. LEN = 0 encodes NUMBER bytes.
- TIMEOUT_BITS, 20: idle bit-times between bytes before a packet is aborted.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in this cycle.
- rx_err  in  1  one-cycle strobe: framing or parity error on the current byte.
- wr_data  out  8  payload byte to the buffer.
- wr_addr  out  clogb2(NUMBER)  buffer address, 0-based payload index.
- wr_clock  out  1  one-cycle write strobe.
- cmd_rx  out  8  command byte of the last completed packet.
- len_rx  out  8  LEN byte of the last completed packet, raw (0 kept as 0).
- pckt_done  out  1  one-cycle pulse at end of packet, good or bad.
- err_code  out  2  valid with pckt_done: 0 OK, 1 checksum, 2 line error, 3 timeout.
- busy  out  1  high while the state is not S_CMD.

Behaviour:
- Reset state: all outputs 0; state S_CMD; checksum accumulator 0; byte counter 0.
- States: S_CMD → S_LEN → S_DATA → S_SUM → S_CMD. Transitions occur only on rx_valid, except for abort paths.
- S_CMD, on rx_valid:
  - cmd register ← rx_data.
  - sum ← rx_data.
  - go to S_LEN.
- S_LEN, on rx_valid:
  - len register ← rx_data.
  - sum ← sum + rx_data.
  - target count = (rx_data == 0) ? NUMBER : rx_data, held in clogb2(NUMBER)+1 bits.
  - cnt ← 0.
  - go to S_DATA.
- S_DATA, on rx_valid:
  - wr_data ← rx_data, wr_addr ← cnt, wr_clock ← 1 for one cycle. Registered, so the write appears 1 cycle after rx_valid.
  - sum ← sum + rx_data.
  - cnt ← cnt + 1.
  - When cnt + 1 == target, go to S_SUM.
- S_SUM, on rx_valid:
  - ok = (rx_data == ~sum).
  - Next cycle: pckt_done = 1; err_code = ok ? 0 : 1; cmd_rx and len_rx updated from the held registers; state → S_CMD.
  - cmd_rx and len_rx update on every pckt_done, including errored packets, and otherwise hold.
- Arithmetic: sum is 8-bit and wraps modulo 256. cnt is clogb2(NUMBER)+1 bits so that 256 is representable.
- rx_err in any state other than S_CMD: abort. Next cycle pckt_done = 1, err_code = 2, state → S_CMD. No write for that byte.
- rx_err in S_CMD: ignored, no pulse.
- rx_err and rx_valid in the same cycle: rx_err wins and the byte is discarded.
- Payload bytes already written before an abort stay in the buffer. The consumer must honour err_code.
- rx_valid arriving in the same cycle as pckt_done: processed normally as a new CMD byte. Back-to-back packets need no idle gap.
- Reset asserted mid-packet: immediate return to reset state. No pckt_done is generated.
- Latency: pckt_done is 1 cycle after the rx_valid of the checksum byte.

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- When defined:
  - An idle counter runs while busy = 1.
  - It clears on every rx_valid and whenever the state is S_CMD.
  - When it reaches TIMEOUT_BITS*(CLOCK/BAUD)-1, the next cycle gives pckt_done = 1, err_code = 3, state → S_CMD.
  - If rx_valid or rx_err arrives in the same cycle the limit is hit, the byte or error takes priority and the counter clears.
- When undefined:
  - No counter logic is generated.
  - The parser waits indefinitely in any state.
  - err_code 3 is never produced.

Decomposition:
- Shared package rx_pkt_pkg contains:
  - the state enum (S_CMD, S_LEN, S_DATA, S_SUM);
  - the err_code localparams ERR_OK, ERR_SUM, ERR_LINE, ERR_TIMEOUT;
  - clogb2, taken from the common include.
- One sub-module, rx_idle_timer, instantiated only under RX_TIMEOUT_EN.
  - Ports: clk, reset, run, clear, expired.
  - Parameter: LIMIT.

Test Plan:
- Bytes 12 02 AA 55 EC → wr_clock at addr 0 (AA) and addr 1 (55); pckt_done with err_code 0, cmd_rx 12, len_rx 02.
- Same packet with final byte ED → two writes, then pckt_done with err_code 1.
- LEN 00 with 256 data bytes of value i and a correct checksum → 256 writes at addr 0..255; err_code 0; len_rx 00.
- rx_err on the 2nd data byte of a len-04 packet → 1 write only; pckt_done with err_code 2; the next packet 12 02 AA 55 EC is parsed OK.
- Reset pulled low after the 3rd byte, then a valid packet sent → no pckt_done from the aborted packet; the new packet gives err_code 0.
- With RX_TIMEOUT_EN: send 12 02 AA and stay silent → pckt_done with err_code 3 exactly 8680 clocks after the AA strobe plus 1; busy returns to 0.
